rvfi_reg_trace_gen: RTL
=======================

# rvfi_reg_trace_gen

Single-channel RVFI register-traffic generator: the transmitting end of the RVFI register-consistency channel. It accepts abstract retire requests (rs1/rs2/rd indices plus rd write data), keeps its own shadow register file, and emits RVFI packets whose rs1/rs2 read data is consistent with all earlier rd writes. It sits in checker self-test benches, where it drives the register-consistency checkers with legal traces and, optionally, deliberately corrupted ones.

## Interface
Parameters:
- XLEN, 32, register width; must equal `RISCV_FORMAL_XLEN` of the checker under test.
- DEPTH, 4, request FIFO entries; power of two, at least 2.

Ports:
- clock  input  1  sole clock, rising edge.
- resetn  input  1  asynchronous, active-low reset.
- req_valid  input  1  retire request present.
- req_ready  output  1  request FIFO not full.
- req_rs1_addr  input  5  source register 1 index.
- req_rs2_addr  input  5  source register 2 index.
- req_rd_addr  input  5  destination index.
- req_rd_wdata  input  XLEN  destination write data.
- out_en  input  1  emit permission; low inserts idle cycles.
- rvfi_valid  output  1  packet valid.
- rvfi_order  output  64  retire order.
- rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr  output  5 each  register indices.
- rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata  output  XLEN each  register data.
- fault_inject  input  1  present only with RVFI_REG_TRACE_FAULT_EN.

## Operation
- Push: the request is written to the FIFO tail on a rising edge with req_valid && req_ready. req_ready = !full and is purely combinational from FIFO state. A full FIFO does not pass requests through, even when a pop happens in the same cycle.
- Pop: on a rising edge with FIFO non-empty and out_en high, the head is removed and all rvfi_* fields are registered.
  - rs1_rdata and rs2_rdata come from the shadow file. Index 0 always reads 0.
  - rd_wdata is forced to 0 when rd_addr == 0.
  - rvfi_valid is 1 for that cycle. It is 0 on every cycle with no pop.
- Shadow write: on the same edge as the pop, shadow[rd_addr] is written with rd_wdata unless rd_addr == 0. Consecutive pops therefore see earlier writes, and no bypass is needed.
- A packet whose rs equals its own rd reads the old value.
- Order: a 64-bit counter starts at 0 and is assigned to each popped packet. It increments by 1 per pop and wraps modulo 2^64.
- Simultaneous push and pop on a non-full FIFO: both take effect and the occupancy is unchanged.
- Pointers are log2(DEPTH)+1 bits. full = (MSBs differ && lower bits equal); empty = (pointers equal).
- Reset, asynchronous and including mid-operation:
  - FIFO is flushed and pointers are set to 0.
  - Shadow file is cleared to 0 and the order counter to 0.
  - rvfi_valid = 0 and all other rvfi_* outputs = 0.
  - req_ready = 1 after reset.
  - The first packet after reset has order 0.

## Timing
- Minimum latency from accept to rvfi_valid: 2 cycles. The push happens at edge N, the pop at edge N+1, and the packet is visible in the cycle after N+1.
- Sustained throughput: 1 packet/cycle while out_en stays high and the FIFO never empties.
- All outputs except req_ready are registered. They hold their last value when rvfi_valid = 0.

## Configuration
- Macro: RVFI_REG_TRACE_FAULT_EN.
- Defined:
  - The fault_inject port exists.
  - If fault_inject is high on a pop edge and the rs1 index is nonzero, bit 0 of that packet's rvfi_rs1_rdata is inverted.
  - The shadow file is unaffected.
- Undefined: the port is absent and every trace is consistent.

## Structure
- Package rvfi_trace_pkg holds:
  - the typedef rvfi_trace_req_t {rs1_addr, rs2_addr, rd_addr, rd_wdata}, parameterised by XLEN through a localparam;
  - the constant for the 64-bit order width.
- Sub-module rvfi_trace_fifo provides the DEPTH-entry synchronous FIFO of rvfi_trace_req_t, with full and empty flags. The top holds the shadow file, the order counter and the output registers.

## Test plan
- Reset release, single push of {rs1=0, rs2=0, rd=5, wdata=0xDEADBEEF}, out_en=1 → rvfi_valid 2 cycles later with order 0 and rd_wdata 0xDEADBEEF.
- Follow-up push of {rs1=5, rs2=5, rd=0, wdata=0x1234} → rs1_rdata = rs2_rdata = 0xDEADBEEF, rd_wdata = 0, order 1, and x5 remains 0xDEADBEEF.
- out_en=0 with DEPTH+1 pushes attempted → req_ready drops after 4 accepts. With out_en=1, 4 back-to-back packets are emitted with orders incrementing by 1, then req_ready returns to 1.
- Single packet {rs1=7, rd=7, wdata=0xA5} after x7 = 0x11 → rs1_rdata = 0x11; the next read of x7 returns 0xA5.
- resetn pulsed low while 3 entries are queued → rvfi_valid = 0 immediately, no queued packet is emitted, the next packet has order 0, and all shadow reads return 0.
- With the macro defined, fault_inject high on the pop of {rs1=5} with x5 = 0xDEADBEEF → rs1_rdata = 0xDEADBEEE, and the paired checker assertion must fail.

Source files
------------

// File: rtl/rvfi_trace_pkg.sv
// rtl/rvfi_trace_pkg.sv - shared types and constants for the RVFI register trace generator
package rvfi_trace_pkg;

  localparam int RVFI_TRACE_XLEN  = 32;
  localparam int RVFI_ORDER_WIDTH = 64;

  typedef struct packed {
    logic [4:0]                 rs1_addr;
    logic [4:0]                 rs2_addr;
    logic [4:0]                 rd_addr;
    logic [RVFI_TRACE_XLEN-1:0] rd_wdata;
  } rvfi_trace_req_t;

endpackage

// File: rtl/rvfi_trace_fifo.sv
// rtl/rvfi_trace_fifo.sv - DEPTH-entry synchronous request FIFO with full/empty flags
module rvfi_trace_fifo
  import rvfi_trace_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic            clock,
  input  logic            resetn,
  input  logic            push_valid,
  input  rvfi_trace_req_t push_data,
  output logic            full,
  input  logic            pop_en,
  output logic            empty,
  output logic            pop_fire,
  output rvfi_trace_req_t pop_data
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]     wr_ptr_q, wr_ptr_d;
  logic [AW:0]     rd_ptr_q, rd_ptr_d;
  rvfi_trace_req_t mem_q [DEPTH];
  rvfi_trace_req_t mem_d [DEPTH];
  logic            push_fire;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign push_fire = push_valid && !full;
  assign pop_fire  = pop_en && !empty;
  assign pop_data  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (push_fire) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop_fire) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/rvfi_reg_trace_gen.sv
// rtl/rvfi_reg_trace_gen.sv - RVFI register-traffic generator with shadow register file
// Optional feature: RVFI_REG_TRACE_FAULT_EN adds fault_inject (flips rs1_rdata bit 0).
module rvfi_reg_trace_gen
  import rvfi_trace_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                        clock,
  input  logic                        resetn,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [4:0]                  req_rs1_addr,
  input  logic [4:0]                  req_rs2_addr,
  input  logic [4:0]                  req_rd_addr,
  input  logic [XLEN-1:0]             req_rd_wdata,
`ifdef RVFI_REG_TRACE_FAULT_EN
  input  logic                        fault_inject,
`endif
  input  logic                        out_en,
  output logic                        rvfi_valid,
  output logic [RVFI_ORDER_WIDTH-1:0] rvfi_order,
  output logic [4:0]                  rvfi_rs1_addr,
  output logic [4:0]                  rvfi_rs2_addr,
  output logic [4:0]                  rvfi_rd_addr,
  output logic [XLEN-1:0]             rvfi_rs1_rdata,
  output logic [XLEN-1:0]             rvfi_rs2_rdata,
  output logic [XLEN-1:0]             rvfi_rd_wdata
);

  rvfi_trace_req_t push_req, head;
  logic            full, empty, pop_fire;

  assign push_req  = '{rs1_addr: req_rs1_addr, rs2_addr: req_rs2_addr,
                       rd_addr: req_rd_addr, rd_wdata: req_rd_wdata};
  assign req_ready = !full;

  rvfi_trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock      (clock),
    .resetn     (resetn),
    .push_valid (req_valid),
    .push_data  (push_req),
    .full       (full),
    .pop_en     (out_en),
    .empty      (empty),
    .pop_fire   (pop_fire),
    .pop_data   (head)
  );

  logic [XLEN-1:0]             shadow_q [32];
  logic [XLEN-1:0]             shadow_d [32];
  logic [RVFI_ORDER_WIDTH-1:0] order_cnt_q, order_cnt_d;
  logic                        valid_q, valid_d;
  logic [RVFI_ORDER_WIDTH-1:0] order_q, order_d;
  logic [4:0]                  rs1_addr_q, rs1_addr_d, rs2_addr_q, rs2_addr_d, rd_addr_q, rd_addr_d;
  logic [XLEN-1:0]             rs1_rdata_q, rs1_rdata_d, rs2_rdata_q, rs2_rdata_d;
  logic [XLEN-1:0]             rd_wdata_q, rd_wdata_d;
  logic [XLEN-1:0]             rd_data_eff;

  assign rd_data_eff = (head.rd_addr == 5'd0) ? '0 : head.rd_wdata;

  // Reads use the pre-edge shadow state, so rs == rd sees the old value.
  always_comb begin
    shadow_d    = shadow_q;
    order_cnt_d = order_cnt_q;
    valid_d     = 1'b0;
    order_d     = order_q;
    rs1_addr_d  = rs1_addr_q;
    rs2_addr_d  = rs2_addr_q;
    rd_addr_d   = rd_addr_q;
    rs1_rdata_d = rs1_rdata_q;
    rs2_rdata_d = rs2_rdata_q;
    rd_wdata_d  = rd_wdata_q;
    if (pop_fire) begin
      valid_d     = 1'b1;
      order_d     = order_cnt_q;
      order_cnt_d = order_cnt_q + 1'b1;
      rs1_addr_d  = head.rs1_addr;
      rs2_addr_d  = head.rs2_addr;
      rd_addr_d   = head.rd_addr;
      rs1_rdata_d = (head.rs1_addr == 5'd0) ? '0 : shadow_q[head.rs1_addr];
      rs2_rdata_d = (head.rs2_addr == 5'd0) ? '0 : shadow_q[head.rs2_addr];
      rd_wdata_d  = rd_data_eff;
`ifdef RVFI_REG_TRACE_FAULT_EN
      if (fault_inject && head.rs1_addr != 5'd0) rs1_rdata_d[0] = ~rs1_rdata_d[0];
`endif
      if (head.rd_addr != 5'd0) shadow_d[head.rd_addr] = rd_data_eff;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 32; i++) shadow_q[i] <= '0;
      order_cnt_q <= '0;
      valid_q     <= 1'b0;
      order_q     <= '0;
      rs1_addr_q  <= '0;
      rs2_addr_q  <= '0;
      rd_addr_q   <= '0;
      rs1_rdata_q <= '0;
      rs2_rdata_q <= '0;
      rd_wdata_q  <= '0;
    end else begin
      shadow_q    <= shadow_d;
      order_cnt_q <= order_cnt_d;
      valid_q     <= valid_d;
      order_q     <= order_d;
      rs1_addr_q  <= rs1_addr_d;
      rs2_addr_q  <= rs2_addr_d;
      rd_addr_q   <= rd_addr_d;
      rs1_rdata_q <= rs1_rdata_d;
      rs2_rdata_q <= rs2_rdata_d;
      rd_wdata_q  <= rd_wdata_d;
    end
  end

  assign rvfi_valid     = valid_q;
  assign rvfi_order     = order_q;
  assign rvfi_rs1_addr  = rs1_addr_q;
  assign rvfi_rs2_addr  = rs2_addr_q;
  assign rvfi_rd_addr   = rd_addr_q;
  assign rvfi_rs1_rdata = rs1_rdata_q;
  assign rvfi_rs2_rdata = rs2_rdata_q;
  assign rvfi_rd_wdata  = rd_wdata_q;

endmodule
